// File: rtl/rast_pkg.sv
// rast_pkg: shared constants, data types and helpers for the rasterizer
// sample-scheduling stage.
//   SIGFIG  bits in color and position words
//   RADIX   fraction bits in position words
//   VERTS   vertices per triangle
//   AXIS    axes per vertex (x,y,z)
//   COLORS  color channels
package rast_pkg;

  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  typedef logic signed [SIGFIG-1:0]  sig_t;
  typedef sig_t [AXIS-1:0]           vertex_t;
  typedef vertex_t [VERTS-1:0]       tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0] color_t;
  // point_t[0] = x, point_t[1] = y
  typedef sig_t [1:0]                point_t;
  // box_t[0] = lower-left, box_t[1] = upper-right
  typedef point_t [1:0]              box_t;

  typedef enum logic {
    WAIT = 1'b0,
    TEST = 1'b1
  } state_t;

  // Sample pitch for 2^ss samples per pixel axis. Values above 4 are
  // clamped so the pitch never drops below 1/16 pixel.
  function automatic sig_t step_from_ss(input logic [2:0] ss);
    logic [2:0] s;
    s = (ss > 3'd4) ? 3'd4 : ss;
    return sig_t'(1) << (RADIX - int'(s));
  endfunction

endpackage

// File: rtl/sample_step_gen.sv
// sample_step_gen: combinational raster-order stepper. Given the current
// sample (x,y), the box corners and the sample pitch, produces the next
// sample position and whether the current sample is the last of the box.
//   x_i, y_i        current sample
//   ll_x_i          box lower-left x (row restart)
//   ur_x_i, ur_y_i  box upper-right corner
//   step_i          sample pitch (positive)
//   next_x_o/y_o    next sample in raster order (x fastest)
//   x_adv_o         next sample stays on the current row
//   y_adv_o         a further row exists
//   last_o          current sample is the final one
module sample_step_gen
  import rast_pkg::*;
(
  input  sig_t x_i,
  input  sig_t y_i,
  input  sig_t ll_x_i,
  input  sig_t ur_x_i,
  input  sig_t ur_y_i,
  input  sig_t step_i,
  output sig_t next_x_o,
  output sig_t next_y_o,
  output logic x_adv_o,
  output logic y_adv_o,
  output logic last_o
);

  // One extra bit so x+step near the top of the range cannot wrap negative.
  logic signed [SIGFIG:0] x_sum, y_sum, ur_x_ext, ur_y_ext;

  always_comb begin
    x_sum    = {x_i[SIGFIG-1], x_i} + {1'b0, step_i};
    y_sum    = {y_i[SIGFIG-1], y_i} + {1'b0, step_i};
    ur_x_ext = {ur_x_i[SIGFIG-1], ur_x_i};
    ur_y_ext = {ur_y_i[SIGFIG-1], ur_y_i};

    x_adv_o  = (x_sum <= ur_x_ext);
    y_adv_o  = (y_sum <= ur_y_ext);
    last_o   = !x_adv_o && !y_adv_o;

    next_x_o = x_adv_o ? x_sum[SIGFIG-1:0] : ll_x_i;
    next_y_o = x_adv_o ? y_i : y_sum[SIGFIG-1:0];
  end

endmodule

// File: rtl/sample_scheduler.sv
// sample_scheduler: accepts one triangle plus bounding box at a time and
// walks the grid-aligned sample positions of the box in raster order, one
// per cycle, towards sampletest.
//   clk, rst         clock (rising edge), async active-low reset
//   tri_R13S         triangle from bbox stage
//   color_R13U       triangle color
//   box_R13S         [0]=LL, [1]=UR, on the sample grid
//   validTri_R13H    triangle/box valid
//   ss_w_lg2_R13U    log2 samples per pixel axis, sampled on accept
//   halt_RnnnnL      downstream stall, low = hold outputs
//   halt_R13L        upstream ready; triangle accepted this cycle if valid
//   tri_R14S         latched triangle
//   color_R14U       latched color
//   sample_R14S      current sample (x,y)
//   validSamp_R14H   sample_R14S valid
//
// state | meaning
// WAIT  | idle, ready for a triangle
// TEST  | walking the box, one sample presented per cycle
module sample_scheduler
  import rast_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  tri_t       tri_R13S,
  input  color_t     color_R13U,
  input  box_t       box_R13S,
  input  logic       validTri_R13H,
  input  logic [2:0] ss_w_lg2_R13U,
  input  logic       halt_RnnnnL,
  output logic       halt_R13L,
  output tri_t       tri_R14S,
  output color_t     color_R14U,
  output point_t     sample_R14S,
  output logic       validSamp_R14H
);

  state_t state_q;
  tri_t   tri_q;
  color_t color_q;
  box_t   box_q;
  sig_t   step_q;
  point_t sample_q;
  logic   valid_q;

  sig_t   next_x, next_y;
  logic   x_adv, y_adv, last;
  logic   accept;

  sample_step_gen u_step (
    .x_i      (sample_q[0]),
    .y_i      (sample_q[1]),
    .ll_x_i   (box_q[0][0]),
    .ur_x_i   (box_q[1][0]),
    .ur_y_i   (box_q[1][1]),
    .step_i   (step_q),
    .next_x_o (next_x),
    .next_y_o (next_y),
    .x_adv_o  (x_adv),
    .y_adv_o  (y_adv),
    .last_o   (last)
  );

  // Ready while idle, or while the final sample is being consumed so the
  // next triangle follows without a bubble.
  assign halt_R13L = (state_q == WAIT) || (state_q == TEST && last && halt_RnnnnL);
  assign accept    = validTri_R13H && halt_R13L;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= WAIT;
      tri_q    <= '0;
      color_q  <= '0;
      box_q    <= '0;
      step_q   <= sig_t'(1) << RADIX;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else if (accept) begin
      state_q  <= TEST;
      tri_q    <= tri_R13S;
      color_q  <= color_R13U;
      box_q    <= box_R13S;
      step_q   <= step_from_ss(ss_w_lg2_R13U);
      sample_q <= box_R13S[0];
      valid_q  <= 1'b1;
    end else if (state_q == TEST && halt_RnnnnL) begin
      if (last) begin
        state_q <= WAIT;
        valid_q <= 1'b0;
      end else begin
        sample_q[0] <= next_x;
        sample_q[1] <= next_y;
      end
    end
  end

  // y_adv is folded into last; kept visible for debug probing.
  logic unused_y_adv;
  assign unused_y_adv = y_adv;

  assign tri_R14S       = tri_q;
  assign color_R14U     = color_q;
  assign sample_R14S    = sample_q;
  assign validSamp_R14H = valid_q;

endmodule

// File: tb/tb_sample_scheduler.sv
module tb_sample_scheduler;
  import rast_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  tri_t       tri_R13S = '0;
  color_t     color_R13U = '0;
  box_t       box_R13S = '0;
  logic       validTri_R13H = 1'b0;
  logic [2:0] ss_w_lg2_R13U = '0;
  logic       halt_RnnnnL = 1'b1;
  logic       halt_R13L;
  tri_t       tri_R14S;
  color_t     color_R14U;
  point_t     sample_R14S;
  logic       validSamp_R14H;

  always #5 clk = ~clk;

  sample_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .tri_R13S       (tri_R13S),
    .color_R13U     (color_R13U),
    .box_R13S       (box_R13S),
    .validTri_R13H  (validTri_R13H),
    .ss_w_lg2_R13U  (ss_w_lg2_R13U),
    .halt_RnnnnL    (halt_RnnnnL),
    .halt_R13L      (halt_R13L),
    .tri_R14S       (tri_R14S),
    .color_R14U     (color_R14U),
    .sample_R14S    (sample_R14S),
    .validSamp_R14H (validSamp_R14H)
  );

  typedef struct {
    int x;
    int y;
    bit last;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 1'b0;
  int   hold_cnt = 0;
  tri_t   last_tri;
  color_t last_color;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: a held sample is compared every cycle, popped only
  // when downstream takes it.
  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (validSamp_R14H) begin
        if (q.size() == 0) begin
          check("spurious_sample", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q[0];
          check("samp_x", 64'(sample_R14S[0]), 64'(24'(e.x)));
          check("samp_y", 64'(sample_R14S[1]), 64'(24'(e.y)));
          check("ready_on_last", 64'(halt_R13L), 64'(e.last && halt_RnnnnL));
          if (halt_RnnnnL) void'(q.pop_front());
          else hold_cnt++;
        end
      end else begin
        check("ready_idle", 64'(halt_R13L), 64'd1);
      end
    end
  end

  task automatic send_tri(input int llx, input int lly, input int urx, input int ury,
                          input logic [2:0] ss);
    int step;
    int budget;
    step = 1 << (10 - int'(ss));
    for (int y = lly; y <= ury; y += step)
      for (int x = llx; x <= urx; x += step) begin
        exp_t e;
        e.x = x;
        e.y = y;
        e.last = (x + step > urx) && (y + step > ury);
        q.push_back(e);
      end
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++) tri_R13S[v][a] = sig_t'($urandom);
    for (int c = 0; c < COLORS; c++) color_R13U[c] = SIGFIG'($urandom);
    box_R13S[0][0] = sig_t'(llx);
    box_R13S[0][1] = sig_t'(lly);
    box_R13S[1][0] = sig_t'(urx);
    box_R13S[1][1] = sig_t'(ury);
    ss_w_lg2_R13U  = ss;
    validTri_R13H  = 1'b1;
    last_tri       = tri_R13S;
    last_color     = color_R13U;
    budget = 0;
    @(negedge clk);
    while (!halt_R13L && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 200) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    validTri_R13H = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (q.size() != 0 && budget < 200) begin
      @(posedge clk);
      #2;
      budget++;
    end
    if (budget >= 200) begin
      check("drain_timeout", 64'd0, 64'd1);
      q.delete();
    end
  endtask

  initial begin
    // reset state
    #3;
    check("rst_valid", 64'(validSamp_R14H), 64'd0);
    check("rst_sample", 64'(sample_R14S), 64'd0);
    check("rst_tri", 64'(tri_R14S[0][0]), 64'd0);
    check("rst_color", 64'(color_R14U[2]), 64'd0);
    check("rst_ready", 64'(halt_R13L), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // case 1: 3x2 samples at step 1024
    send_tri(0, 0, 2048, 1024, 3'd0);
    check("tri_latch", 64'(tri_R14S[2][1]), 64'(last_tri[2][1]));
    check("color_latch", 64'(color_R14U[1]), 64'(last_color[1]));
    check("first_valid", 64'(validSamp_R14H), 64'd1);
    wait_drain();
    check("c1_wait", 64'(validSamp_R14H), 64'd0);

    // case 2: 2x2 samples at step 512
    send_tri(0, 0, 512, 512, 3'd1);
    wait_drain();
    check("c2_wait", 64'(validSamp_R14H), 64'd0);

    // case 3: degenerate box, single sample for a single cycle
    send_tri(3072, -1024, 3072, -1024, 3'd0);
    check("c3_valid", 64'(validSamp_R14H), 64'd1);
    wait_drain();
    check("c3_one_cycle", 64'(validSamp_R14H), 64'd0);

    // case 4: stall 3 cycles on the second sample
    hold_cnt = 0;
    send_tri(0, 0, 2048, 1024, 3'd0);
    @(posedge clk);
    #1;
    halt_RnnnnL = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    halt_RnnnnL = 1'b1;
    wait_drain();
    check("c4_hold_cycles", 64'(hold_cnt), 64'd3);
    check("c4_wait", 64'(validSamp_R14H), 64'd0);

    // case 5: second triangle queued during the walk, taken on the last sample
    send_tri(0, 0, 2048, 1024, 3'd0);
    send_tri(4096, 2048, 4608, 2560, 3'd1);
    check("c5_no_bubble", 64'(validSamp_R14H), 64'd1);
    check("c5_ll_x", 64'(sample_R14S[0]), 64'd4096);
    wait_drain();
    check("c5_wait", 64'(validSamp_R14H), 64'd0);

    // case 6: async reset mid-walk
    send_tri(0, 0, 2048, 1024, 3'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    check("c6_valid_async", 64'(validSamp_R14H), 64'd0);
    check("c6_sample_async", 64'(sample_R14S), 64'd0);
    check("c6_tri_async", 64'(tri_R14S[1][1]), 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("c6_wait_after", 64'(validSamp_R14H), 64'd0);
    check("c6_ready_after", 64'(halt_R13L), 64'd1);
    mon_en = 1'b1;

    // walk after reset still correct
    send_tri(1024, 1024, 2048, 1024, 3'd0);
    wait_drain();
    check("post_rst_wait", 64'(validSamp_R14H), 64'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
